// File: rtl/mac_array_feeder_if.sv
// Input beat bus of the MAC array feeder: valid/ready handshake carrying one
// x vector, one w vector, the job-last flag and the dot-product length.
interface mac_array_feeder_if #(
    parameter int LANES = 8,
    parameter int DW    = 32,
    parameter int LENW  = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [LANES*DW-1:0] in_x;
    logic [LANES*DW-1:0] in_w;
    logic                in_last;
    logic [LENW-1:0]     len;

    modport master (
        output in_valid, in_x, in_w, in_last, len,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_x, in_w, in_last, len,
        output in_ready
    );
endinterface

// File: rtl/mac_array_feeder.sv
// Skewing operand feeder for the LANES x LANES systolic MAC array.
// Lane i is delayed by i enabled cycles so operands enter the array on a
// diagonal. A per-row clear marks the first beat of each dot product, and a
// zero-data flush beat with clear=1 closes every job.
module mac_array_feeder #(
    parameter int LANES = 8,
    parameter int DW    = 32,
    parameter int LENW  = 16
) (
    input  logic                clk,
    input  logic                reset,
    mac_array_feeder_if.slave   in_if,
    input  logic                hold,
    output logic [LANES*DW-1:0] x_out,
    output logic [LANES*DW-1:0] w_out,
    output logic [LANES-1:0]    clear_out,
    output logic                enable,
    output logic                busy,
    output logic                done
);
    localparam int DCW = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [LENW-1:0]     cnt_q;
    logic [LENW-1:0]     len_q;
    logic [DCW-1:0]      dcnt_q;
    logic                accept;
    logic [LENW-1:0]     len_sel;
    logic [LENW-1:0]     len_eff;
    logic [LENW-1:0]     cnt_inc;
    logic [LANES*DW-1:0] st0_x;
    logic [LANES*DW-1:0] st0_w;
    logic                st0_clr;

    assign enable         = ~hold & ~reset;
    assign in_if.in_ready = ((state_q == IDLE) || (state_q == STREAM)) && enable;
    assign accept         = in_if.in_valid & in_if.in_ready;
    assign busy           = (state_q != IDLE);

    // The first beat of a job uses the length on the bus; later beats use the latched one.
    assign len_sel = (state_q == IDLE) ? in_if.len : len_q;
    assign len_eff = (len_sel == '0) ? LENW'(1) : len_sel;
    assign cnt_inc = cnt_q + LENW'(1);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; accept already implies enable, FLUSH/DRAIN wait for enable.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, STREAM: if (accept) state_d = in_if.in_last ? FLUSH : STREAM;
            FLUSH:        if (enable) state_d = DRAIN;
            DRAIN:        if (enable && dcnt_q == DCW'(LANES - 2)) state_d = IDLE;
            default:      state_d = IDLE;
        endcase
    end

    // Stage-0 word: accepted beat, flush beat (zero data, clear) or zero bubble.
    always_comb begin
        st0_x   = '0;
        st0_w   = '0;
        st0_clr = 1'b0;
        if (accept) begin
            st0_x   = in_if.in_x;
            st0_w   = in_if.in_w;
            st0_clr = (cnt_q == '0);
        end else if (state_q == FLUSH) begin
            st0_clr = 1'b1;
        end
    end

    // Beat counter, length latch, drain counter and done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            len_q  <= '0;
            dcnt_q <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                if (state_q == IDLE) len_q <= len_eff;
                if (in_if.in_last || cnt_inc == len_eff) cnt_q <= '0;
                else                                     cnt_q <= cnt_inc;
            end
            if (enable) begin
                if (state_q == FLUSH) dcnt_q <= '0;
                if (state_q == DRAIN) begin
                    dcnt_q <= dcnt_q + DCW'(1);
                    if (dcnt_q == DCW'(LANES - 2)) done <= 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DW-1:0] xs [i+1];
        logic [DW-1:0] ws [i+1];
        logic [i:0]    cs;

        // Lane i delay line: i+1 registers, advancing only on enabled cycles.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int unsigned j = 0; j < i + 1; j++) begin
                    xs[j] <= '0;
                    ws[j] <= '0;
                end
                cs <= '0;
            end else if (enable) begin
                xs[0] <= st0_x[i*DW +: DW];
                ws[0] <= st0_w[i*DW +: DW];
                cs[0] <= st0_clr;
                for (int unsigned j = 1; j < i + 1; j++) begin
                    xs[j] <= xs[j-1];
                    ws[j] <= ws[j-1];
                    cs[j] <= cs[j-1];
                end
            end
        end

        assign x_out[i*DW +: DW] = xs[i];
        assign w_out[i*DW +: DW] = ws[i];
        assign clear_out[i]      = cs[i];
    end
endmodule
